// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: datapath width and
// the fetch sequencer state encoding.
package fetch_unit_pkg;

  localparam int FETCH_WORD_SIZE = 16;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/ready bus; fetch is the master, memory the slave.
interface fetch_unit_if
  import fetch_unit_pkg::*;
#(
  parameter int WORD_SIZE = FETCH_WORD_SIZE
) ();

  logic                 imem_read;
  logic [WORD_SIZE-1:0] imem_addr;
  logic                 imem_ready;
  logic [WORD_SIZE-1:0] imem_data;

  modport master (output imem_read, imem_addr, input imem_ready, imem_data);
  modport slave  (input imem_read, imem_addr, output imem_ready, imem_data);

endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry holding buffer for a fetched instruction that ID could not take.
module fetch_skid_buf #(
  parameter int W = 49
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic         unload,
  input  logic         clear,
  input  logic [W-1:0] din,
  output logic         valid,
  output logic [W-1:0] dout
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid <= 1'b0;
      dout  <= '0;
    end else begin
      if (clear || unload) valid <= 1'b0;
      else if (load)       valid <= 1'b1;
      if (load && !clear)  dout  <= din;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// IF stage: holds the fetch PC, runs a single-outstanding imem handshake,
// steers via the predictor, skids one instruction on ID stall, and drains on redirect.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                   WORD_SIZE = FETCH_WORD_SIZE,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  output logic [WORD_SIZE-1:0] bp_pc,
  input  logic [WORD_SIZE-1:0] bp_predicted_pc,
  input  logic                 bp_tag_match,
  fetch_unit_if.master         imem,
  input  logic                 id_stall,
  input  logic                 redirect,
  input  logic [WORD_SIZE-1:0] redirect_pc,
  output logic                 if_id_valid,
  output logic [WORD_SIZE-1:0] if_id_inst,
  output logic [WORD_SIZE-1:0] if_id_pc,
  output logic [WORD_SIZE-1:0] if_id_pred_pc,
  output logic                 if_id_tag_match,
  output logic [WORD_SIZE-1:0] fetch_count
);

  // Entry layout: {inst, pc, pred_pc, tag_match}
  localparam int ENTRY_W = 3*WORD_SIZE + 1;

  fetch_state_e         state_q, state_d;
  logic [WORD_SIZE-1:0] pc_q, pc_d;
  logic [WORD_SIZE-1:0] drain_q, drain_d;
  logic [WORD_SIZE-1:0] cnt_q, cnt_d;
  logic                 iv_q, iv_d;
  logic [ENTRY_W-1:0]   ent_q, ent_d;
  logic [ENTRY_W-1:0]   cap, sk_dout;
  logic                 accept, consumed;
  logic                 sk_load, sk_unload, sk_clr, sk_valid;

  assign accept   = !iv_q || !id_stall;
  assign consumed = iv_q && !id_stall;
  assign cap      = {imem.imem_data, pc_q, bp_predicted_pc, bp_tag_match};

  assign bp_pc          = pc_q;
  assign imem.imem_read = (state_q == S_FETCH) || (state_q == S_DRAIN);
  assign imem.imem_addr = (state_q == S_DRAIN) ? drain_q : pc_q;
  assign if_id_valid    = iv_q;
  assign {if_id_inst, if_id_pc, if_id_pred_pc, if_id_tag_match} = ent_q;
  assign fetch_count    = cnt_q;

  fetch_skid_buf #(.W(ENTRY_W)) u_skid (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (sk_load),
    .unload  (sk_unload),
    .clear   (sk_clr),
    .din     (cap),
    .valid   (sk_valid),
    .dout    (sk_dout)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    drain_d   = drain_q;
    iv_d      = iv_q && !consumed;
    ent_d     = ent_q;
    cnt_d     = cnt_q;
    sk_load   = 1'b0;
    sk_unload = 1'b0;
    sk_clr    = 1'b0;
    if (redirect) begin
      iv_d   = 1'b0;
      sk_clr = 1'b0 | 1'b1;
      pc_d   = redirect_pc;
      unique case (state_q)
        // An in-flight request must still be absorbed before a new one issues.
        S_FETCH: begin
          if (!imem.imem_ready) begin
            drain_d = pc_q;
            state_d = S_DRAIN;
          end else begin
            state_d = S_FETCH;
          end
        end
        S_DRAIN: if (imem.imem_ready) state_d = S_FETCH;
        default: state_d = S_FETCH;
      endcase
    end else begin
      unique case (state_q)
        S_FETCH: begin
          if (imem.imem_ready) begin
            pc_d = bp_predicted_pc;
            if (accept) begin
              ent_d = cap;
              iv_d  = 1'b1;
              cnt_d = cnt_q + WORD_SIZE'(1);
            end else begin
              sk_load = 1'b1;
              state_d = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (accept && sk_valid) begin
            ent_d     = sk_dout;
            iv_d      = 1'b1;
            cnt_d     = cnt_q + WORD_SIZE'(1);
            sk_unload = 1'b1;
            state_d   = S_FETCH;
          end
        end
        S_DRAIN: if (imem.imem_ready) state_d = S_FETCH;
        default: state_d = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      drain_q <= '0;
      iv_q    <= 1'b0;
      ent_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drain_q <= drain_d;
      iv_q    <= iv_d;
      ent_q   <= ent_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch (IF) stage feeding the `branch_predictor` and the IF/ID pipeline register. Holds the architectural fetch PC and runs a single-outstanding request/ready handshake to instruction memory. Steers the next PC from the predictor's combinational `branch_predicted_pc`, buffers one instruction when ID stalls, and drops wrong-path fetches on a redirect from ID (jump) or EX (branch).

## Interface
Parameters:
- `WORD_SIZE`, 16: datapath/address width; from `constants.v`.
- `RESET_PC`, 16'h0000: PC loaded on reset.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `bp_pc`  out  WORD_SIZE  PC presented to the predictor; always equals `pc`.
- `bp_predicted_pc`  in  WORD_SIZE  predictor's next PC for `bp_pc`; combinational.
- `bp_tag_match`  in  1  predictor BTB hit for `bp_pc`.
- `imem_read`  out  1  instruction-memory request.
- `imem_addr`  out  WORD_SIZE  request address; stable while `imem_read`=1.
- `imem_ready`  in  1  one-cycle pulse; `imem_data` is valid.
- `imem_data`  in  WORD_SIZE  fetched instruction.
- `id_stall`  in  1  ID cannot accept a new instruction this cycle.
- `redirect`  in  1  flush wrong path; the highest-priority event.
- `redirect_pc`  in  WORD_SIZE  correct next PC.
- `if_id_valid`  out  1  IF/ID register holds a live instruction.
- `if_id_inst`  out  WORD_SIZE  instruction.
- `if_id_pc`  out  WORD_SIZE  PC of the instruction.
- `if_id_pred_pc`  out  WORD_SIZE  predicted next PC; ID/EX compare it against the real target.
- `if_id_tag_match`  out  1  BTB hit at fetch.
- `fetch_count`  out  WORD_SIZE  count of instructions loaded into IF/ID; wraps at 2^WORD_SIZE.

## Operation
- State register:
  - `S_FETCH`: `imem_read`=1, `imem_addr`=`pc`.
  - `S_HOLD`: skid buffer full; `imem_read`=0.
  - `S_DRAIN`: `imem_read`=1, `imem_addr`=`drain_addr`; the result is discarded.
- Accept condition: `accept` = `!if_id_valid || !id_stall`. ID consumes IF/ID at any edge where `if_id_valid && !id_stall`.
- S_FETCH with `imem_ready`:
  - `pc` ← `bp_predicted_pc`.
  - `{inst, pc, bp_predicted_pc, bp_tag_match}` is captured.
  - If `accept`, the capture goes to IF/ID and the state stays S_FETCH.
  - Otherwise the capture goes to the skid buffer and the state moves to S_HOLD.
- S_FETCH without `imem_ready`: `pc` and the address hold. IF/ID is invalidated if consumed.
- S_HOLD: when `accept`, the skid buffer moves to IF/ID, the skid buffer is cleared, and the state returns to S_FETCH.
- `redirect` overrides all of the above in every state:
  - `if_id_valid` ← 0, skid buffer cleared, `pc` ← `redirect_pc`.
  - From S_FETCH with no `imem_ready` in the same cycle: `drain_addr` ← old `pc`, go to S_DRAIN.
  - Otherwise: go to S_FETCH.
- S_DRAIN: on `imem_ready`, data is dropped and the state moves to S_FETCH. A further `redirect` in S_DRAIN only updates `pc`.
- `fetch_count` increments on every IF/ID load, including a skid-buffer transfer, and never on a redirect cycle.
- No predictor state is written here; the ID and EX stages drive BTB/BHT updates.

## Timing
- Reset (asynchronous assert, synchronous release):
  - State S_FETCH, `pc`=`RESET_PC`, `if_id_valid`=0, skid buffer empty.
  - IF/ID fields are 0, `fetch_count`=0, `drain_addr`=0.
  - `imem_read` is 1 from the first cycle after release.
- Latency: instruction at IF/ID one edge after `imem_ready`. Back-to-back fetches give throughput of 1 per cycle when memory returns same-cycle ready.
- Zero-latency memory is legal: `imem_ready` may assert in the same cycle as the request.
- Reset mid-request: state clears immediately. The outstanding memory response is not tracked; memory is reset by the same `reset_n`.
- Simultaneous events:
  - `redirect` with `imem_ready`: data discarded, no drain.
  - `redirect` with `id_stall`: flush still occurs.

## Structure
- `WORD_SIZE` stays in `constants.v`.
- State encodings `S_FETCH`, `S_HOLD`, `S_DRAIN` go as localparams in a shared `fetch_defs.v`.
- One sub-module, `fetch_skid_buf`: a 1-entry buffer with load/unload/clear and valid.
- The predictor is instantiated beside this block at CPU level, not inside it.

## Test plan
- Straight line, no stall, same-cycle ready, predictor returns pc+1 → IF/ID PCs are 0,1,2,3 on consecutive cycles and `fetch_count`=4 after 4 loads.
- BTB hit: `bp_predicted_pc`=16'h0040 at pc 2 → next `imem_addr`=16'h0040, `if_id_tag_match`=1, `if_id_pred_pc`=16'h0040.
- `id_stall` held 3 cycles with IF/ID full → one instruction goes to the skid buffer, `imem_read`=0 in S_HOLD. On release, the skid instruction appears next and no instruction is lost or duplicated.
- 3-cycle memory latency, `redirect` to 16'h0100 one cycle after a request to 16'h0005 → `imem_addr` stays 16'h0005 until ready, that data never reaches IF/ID, then the request to 16'h0100 issues.
- `redirect` coincident with `imem_ready` and with `id_stall`=1 → `if_id_valid`=0 next cycle, skid buffer empty, no S_DRAIN, `pc`=`redirect_pc`.
- `reset_n` asserted mid-S_HOLD → outputs return to their reset values without a clock edge; fetch restarts at `RESET_PC` after release.
